// File: rtl/sd_sacq_window.sv
// sd_sacq_window: turns the coder event word into the acquisition gate, ADC trigger strobes, counters and switch gate.
// Latency: i_code edge to registered output is 3 clk_sys cycles; no backpressure, the block free-runs every cycle.
module sd_sacq_window #(
  parameter int SAMPLE_DIV = 40,
  parameter int SCNT_W     = 12,
  parameter int ECNT_W     = 10
) (
  input  logic              clk_sys,
  input  logic              rst,
  input  logic [10:0]       i_code,
  input  logic [SCNT_W-1:0] samp_max,
  output logic              acq_gate,
  output logic              adc_trig,
  output logic [SCNT_W-1:0] samp_cnt,
  output logic              acq_done,
  output logic [ECNT_W-1:0] echo_cnt,
  output logic              sw_gate,
  output logic              ch_sel,
  output logic              phase180
);

  localparam int DIV_W = (SAMPLE_DIV > 2) ? $clog2(SAMPLE_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    ACQ   = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state_q, state_d;

  logic [10:0]       s1_q, s1_d;
  logic [10:0]       s2_q, s2_d;
  logic [6:0]        s3_q, s3_d;
  logic [DIV_W-1:0]  div_q, div_d;
  logic              acq_gate_q, acq_gate_d;
  logic              adc_trig_q, adc_trig_d;
  logic [SCNT_W-1:0] samp_cnt_q, samp_cnt_d;
  logic              acq_done_q, acq_done_d;
  logic [ECNT_W-1:0] echo_cnt_q, echo_cnt_d;
  logic              sw_gate_q, sw_gate_d;
  logic              ch_sel_q, ch_sel_d;
  logic              phase180_q, phase180_d;

  logic [6:0]        ev_rise;
  logic              start, bbch, ph180, longo;
  logic              ev1_rise, ev2_rise, ev3_rise;
  logic              div_last, trig_now, hit_max, win_close;
  logic [SCNT_W-1:0] samp_inc;
  logic              sw_set, sw_clr;

  // Only the event bits need the third stage; the level bits are used straight from s2.
  always_comb begin
    s1_d = i_code;
    s2_d = s1_q;
    s3_d = s2_q[10:4];
  end

  always_comb begin
    ev_rise  = s2_q[10:4] & ~s3_q;
    start    = s2_q[0];
    bbch     = s2_q[1];
    ph180    = s2_q[2];
    longo    = s2_q[3];
    ev1_rise = ev_rise[0];
    ev2_rise = ev_rise[1];
    ev3_rise = ev_rise[2];
  end

  // A realign or a close on the terminal divider cycle suppresses that trigger.
  always_comb begin
    div_last  = (div_q == DIV_LAST);
    trig_now  = (state_q == ACQ) && div_last && !ev2_rise && !ev3_rise;
    samp_inc  = (samp_cnt_q == {SCNT_W{1'b1}}) ? samp_cnt_q : samp_cnt_q + 1'b1;
    hit_max   = trig_now && (samp_max != '0) && (samp_inc == samp_max);
    win_close = (state_q == ACQ) && (ev3_rise || hit_max);
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!start) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:        state_d = ARMED;
        ARMED, HOLD: if (ev1_rise) state_d = ACQ;
        ACQ:         if (win_close) state_d = HOLD;
        default:     state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    acq_gate_d = acq_gate_q;
    adc_trig_d = 1'b0;
    acq_done_d = 1'b0;
    samp_cnt_d = samp_cnt_q;
    echo_cnt_d = echo_cnt_q;
    div_d      = div_q;
    ch_sel_d   = ch_sel_q;
    phase180_d = phase180_q;
    if (!start) begin
      acq_gate_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          echo_cnt_d = '0;
        end
        ARMED, HOLD: begin
          if (ev1_rise) begin
            acq_gate_d = 1'b1;
            samp_cnt_d = '0;
            div_d      = '0;
            ch_sel_d   = bbch;
            phase180_d = ph180;
          end
        end
        ACQ: begin
          if (ev2_rise && !ev3_rise) begin
            // The realign cycle itself counts as divider phase 0.
            div_d = DIV_W'(1);
          end else if (trig_now) begin
            div_d      = '0;
            adc_trig_d = 1'b1;
            samp_cnt_d = samp_inc;
          end else begin
            div_d = div_q + DIV_W'(1);
          end
          if (win_close) begin
            acq_gate_d = 1'b0;
            acq_done_d = 1'b1;
            echo_cnt_d = echo_cnt_q + 1'b1;
          end
        end
        default: begin
          acq_gate_d = 1'b0;
        end
      endcase
    end
  end

  // Switch gate ignores the FSM; clear beats set when both rise together.
  always_comb begin
    sw_set    = longo ? ev_rise[5] : ev_rise[3];
    sw_clr    = longo ? ev_rise[6] : ev_rise[4];
    sw_gate_d = sw_gate_q;
    if (!start || sw_clr) begin
      sw_gate_d = 1'b0;
    end else if (sw_set) begin
      sw_gate_d = 1'b1;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (rst) begin
      s1_q       <= '0;
      s2_q       <= '0;
      s3_q       <= '0;
      div_q      <= '0;
      acq_gate_q <= 1'b0;
      adc_trig_q <= 1'b0;
      samp_cnt_q <= '0;
      acq_done_q <= 1'b0;
      echo_cnt_q <= '0;
      sw_gate_q  <= 1'b0;
      ch_sel_q   <= 1'b0;
      phase180_q <= 1'b0;
    end else begin
      s1_q       <= s1_d;
      s2_q       <= s2_d;
      s3_q       <= s3_d;
      div_q      <= div_d;
      acq_gate_q <= acq_gate_d;
      adc_trig_q <= adc_trig_d;
      samp_cnt_q <= samp_cnt_d;
      acq_done_q <= acq_done_d;
      echo_cnt_q <= echo_cnt_d;
      sw_gate_q  <= sw_gate_d;
      ch_sel_q   <= ch_sel_d;
      phase180_q <= phase180_d;
    end
  end

  assign acq_gate = acq_gate_q;
  assign adc_trig = adc_trig_q;
  assign samp_cnt = samp_cnt_q;
  assign acq_done = acq_done_q;
  assign echo_cnt = echo_cnt_q;
  assign sw_gate  = sw_gate_q;
  assign ch_sel   = ch_sel_q;
  assign phase180 = phase180_q;

endmodule

// File: tb/tb_sd_sacq_window.sv
// Bench for sd_sacq_window: random coder event streams against a cycle-level behavioural model.
// Windows are tracked as open/closed flags and triggers as absolute due-cycle numbers.
module tb_sd_sacq_window;

  localparam int SD     = 4;
  localparam int SCNT_W = 12;
  localparam int ECNT_W = 10;
  localparam int SMAX   = (1 << SCNT_W) - 1;
  localparam int NCYC   = 20000;

  logic              clk_sys = 1'b0;
  logic              rst;
  logic [10:0]       i_code;
  logic [SCNT_W-1:0] samp_max;
  logic              acq_gate, adc_trig, acq_done, sw_gate, ch_sel, phase180;
  logic [SCNT_W-1:0] samp_cnt;
  logic [ECNT_W-1:0] echo_cnt;

  sd_sacq_window #(.SAMPLE_DIV(SD), .SCNT_W(SCNT_W), .ECNT_W(ECNT_W)) dut (
    .clk_sys  (clk_sys),
    .rst      (rst),
    .i_code   (i_code),
    .samp_max (samp_max),
    .acq_gate (acq_gate),
    .adc_trig (adc_trig),
    .samp_cnt (samp_cnt),
    .acq_done (acq_done),
    .echo_cnt (echo_cnt),
    .sw_gate  (sw_gate),
    .ch_sel   (ch_sel),
    .phase180 (phase180)
  );

  always #5 clk_sys = ~clk_sys;

  int n_chk = 0;
  int n_err = 0;
  int cyc   = 0;

  // Model state: codes sampled at the last four edges, newest first.
  logic [10:0] hist [0:3];
  bit  m_active, m_open, m_trig, m_done, m_sw, m_ch, m_ph;
  int  m_samp, m_echo, n_trig_due;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask

  task automatic model_close();
    m_open = 1'b0;
    m_done = 1'b1;
    m_echo = (m_echo + 1) % (1 << ECNT_W);
  endtask

  // One call per rising edge, using the inputs present at that edge.
  task automatic model_step();
    logic [10:0] lvl, prv;
    logic [6:0]  rise;
    bit          set_sw, clr_sw;
    cyc++;
    m_trig = 1'b0;
    m_done = 1'b0;
    if (rst) begin
      for (int i = 0; i < 4; i++) hist[i] = '0;
      m_active = 0; m_open = 0; m_sw = 0; m_ch = 0; m_ph = 0;
      m_samp = 0; m_echo = 0; n_trig_due = 0;
      return;
    end
    for (int i = 3; i > 0; i--) hist[i] = hist[i-1];
    hist[0] = i_code;
    lvl  = hist[2];
    prv  = hist[3];
    rise = lvl[10:4] & ~prv[10:4];
    if (!lvl[0]) begin
      m_active = 0;
      m_open   = 0;
      m_sw     = 0;
      return;
    end
    if (!m_active) begin
      m_active = 1;
      m_echo   = 0;
    end else if (!m_open) begin
      if (rise[0]) begin
        m_open     = 1;
        m_samp     = 0;
        m_ch       = lvl[1];
        m_ph       = lvl[2];
        n_trig_due = cyc + SD;
      end
    end else begin
      if (rise[2]) begin
        model_close();
      end else if (rise[1]) begin
        n_trig_due = cyc + SD - 1;
      end else if (cyc == n_trig_due) begin
        m_trig     = 1;
        m_samp     = (m_samp == SMAX) ? SMAX : m_samp + 1;
        n_trig_due = cyc + SD;
        if (samp_max != 0 && m_samp == int'(samp_max)) model_close();
      end
    end
    set_sw = lvl[3] ? rise[5] : rise[3];
    clr_sw = lvl[3] ? rise[6] : rise[4];
    if (clr_sw)      m_sw = 0;
    else if (set_sw) m_sw = 1;
  endtask

  task automatic compare_all();
    check("acq_gate", 32'(acq_gate), 32'(m_open));
    check("adc_trig", 32'(adc_trig), 32'(m_trig));
    check("samp_cnt", 32'(samp_cnt), 32'(m_samp));
    check("acq_done", 32'(acq_done), 32'(m_done));
    check("echo_cnt", 32'(echo_cnt), 32'(m_echo));
    check("sw_gate",  32'(sw_gate),  32'(m_sw));
    check("ch_sel",   32'(ch_sel),   32'(m_ch));
    check("phase180", 32'(phase180), 32'(m_ph));
  endtask

  function automatic logic [10:0] next_code(input logic [10:0] cur);
    logic [10:0] c;
    c = cur;
    if (!c[0]) c[0] = ($urandom_range(0, 7) == 0);
    else       c[0] = ($urandom_range(0, 299) != 0);
    for (int b = 1; b <= 3; b++)
      if ($urandom_range(0, 49) == 0) c[b] = ~c[b];
    c[4] = ($urandom_range(0, 12) == 0);
    c[5] = ($urandom_range(0, 30) == 0);
    c[6] = ($urandom_range(0, 80) == 0);
    for (int b = 7; b <= 10; b++) c[b] = ($urandom_range(0, 8) == 0);
    return c;
  endfunction

  int rst_left;

  initial begin
    rst      = 1'b1;
    i_code   = 11'h7FF;
    samp_max = SCNT_W'(5);
    rst_left = 0;
    for (int i = 0; i < 4; i++) hist[i] = '0;
    for (int k = 0; k < 2; k++) begin
      @(posedge clk_sys);
      model_step();
      @(negedge clk_sys);
      compare_all();
    end
    // All bits held high after release: only start may act once synced.
    rst = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(posedge clk_sys);
      model_step();
      @(negedge clk_sys);
      compare_all();
    end
    for (int k = 0; k < NCYC; k++) begin
      if (rst_left > 0) begin
        rst_left--;
        rst = (rst_left > 0);
      end else if ($urandom_range(0, 2999) == 0) begin
        rst      = 1'b1;
        rst_left = $urandom_range(1, 2) + 1;
      end
      if ($urandom_range(0, 499) == 0) samp_max = SCNT_W'($urandom_range(0, 6));
      i_code = next_code(i_code);
      @(posedge clk_sys);
      model_step();
      @(negedge clk_sys);
      compare_all();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
